// File: rtl/microseq_ctrl.sv
// Microcode sequencer: opcode dispatch into a writable microcode RAM, issuing one
// control word per cycle until an end-of-segment word, with halt/fault terminal states.
module microseq_ctrl #(
  parameter int CTRL_WIDTH = 32,
  parameter int UADDR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [UADDR_W-1:0]    cfg_addr,
  input  logic [CTRL_WIDTH-1:0] cfg_data,
  input  logic                  seg_we,
  input  logic [5:0]            seg_op,
  input  logic [UADDR_W-1:0]    seg_ptr,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic                  opcode_valid,
  input  logic                  stall,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  ctrl_valid,
  output logic                  fetch_req,
  output logic [UADDR_W-1:0]    upc,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DISPATCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [5:0]         OP_HALT = 6'h3F;
  localparam logic [UADDR_W-1:0] UPC_MAX = '1;

  logic [CTRL_WIDTH-1:0] ram     [2**UADDR_W];
  logic [UADDR_W-1:0]    seg_tab [64];
  logic [63:0]           seg_valid;
  state_t                state;
  logic [5:0]            op_q;
  logic                  eos_pend;
  logic                  wrap_pend;
  logic                  cfg_ok;

  // Programming is only possible while the sequencer is parked.
  assign cfg_ok = (state == S_IDLE) || (state == S_HALT) || (state == S_FAULT);

  // NOTE: storage arrays have no reset; only the valid bits (below) are cleared.
  always_ff @(posedge clk) begin
    if (cfg_ok && cfg_we) ram[cfg_addr] <= cfg_data;
    if (cfg_ok && seg_we) seg_tab[seg_op] <= seg_ptr;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
      fetch_req  <= 1'b0;
      upc        <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      seg_valid  <= '0;
      op_q       <= '0;
      eos_pend   <= 1'b0;
      wrap_pend  <= 1'b0;
    end else begin
      if (cfg_ok && seg_we) seg_valid[seg_op] <= 1'b1;

      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
            busy      <= 1'b1;
            halted    <= 1'b0;
            fault     <= 1'b0;
          end
        end

        S_FETCH: begin
          if (opcode_valid) begin
            op_q      <= opcode;
            fetch_req <= 1'b0;
            if (opcode == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
              ctrl   <= '0;
            end else if (!seg_valid[opcode]) begin
              state <= S_FAULT;
              fault <= 1'b1;
              busy  <= 1'b0;
              ctrl  <= '0;
            end else begin
              state <= S_DISPATCH;
            end
          end
        end

        S_DISPATCH: begin
          upc       <= seg_tab[op_q];
          eos_pend  <= 1'b0;
          wrap_pend <= 1'b0;
          state     <= S_EXEC;
        end

        S_EXEC: begin
          // The last issued word stays on ctrl for one cycle before leaving EXEC.
          if (stall) begin
            ctrl_valid <= 1'b0;
          end else if (eos_pend) begin
            state      <= S_FETCH;
            ctrl_valid <= 1'b0;
            fetch_req  <= 1'b1;
            eos_pend   <= 1'b0;
          end else if (wrap_pend) begin
            state      <= S_FAULT;
            ctrl       <= '0;
            ctrl_valid <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b1;
            wrap_pend  <= 1'b0;
          end else begin
            ctrl       <= ram[upc];
            ctrl_valid <= 1'b1;
            if (ram[upc][0]) begin
              eos_pend <= 1'b1;
              upc      <= upc + 1'b1;
            end else if (upc == UPC_MAX) begin
              wrap_pend <= 1'b1;
            end else begin
              upc <= upc + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl: directed scenarios plus randomized programs
// checked against a segment-walking reference model.
module tb_microseq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        seg_we;
  logic [5:0]  seg_op;
  logic [7:0]  seg_ptr;
  logic        start;
  logic [5:0]  opcode;
  logic        opcode_valid;
  logic        stall;
  logic [31:0] ctrl;
  logic        ctrl_valid;
  logic        fetch_req;
  logic [7:0]  upc;
  logic        busy;
  logic        halted;
  logic        fault;

  microseq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .seg_we       (seg_we),
    .seg_op       (seg_op),
    .seg_ptr      (seg_ptr),
    .start        (start),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .stall        (stall),
    .ctrl         (ctrl),
    .ctrl_valid   (ctrl_valid),
    .fetch_req    (fetch_req),
    .upc          (upc),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the programmed tables should contain.
  logic [31:0] m_ram   [256];
  logic [7:0]  m_ptr   [64];
  bit          m_valid [64];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          exp_end;  // 0: back to fetch, 1: halt, 2: fault

  always @(negedge clk) if (ctrl_valid) obs_q.push_back(ctrl);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d, input bit upd);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (upd) m_ram[a] = d;
  endtask

  task automatic seg_write(input logic [5:0] op, input logic [7:0] p, input bit upd);
    seg_we = 1'b1; seg_op = op; seg_ptr = p;
    tick();
    seg_we = 1'b0;
    if (upd) begin m_ptr[op] = p; m_valid[op] = 1'b1; end
  endtask

  task automatic both_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [5:0] op, input logic [7:0] p);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    seg_we = 1'b1; seg_op = op; seg_ptr = p;
    tick();
    cfg_we = 1'b0; seg_we = 1'b0;
    m_ram[a] = d; m_ptr[op] = p; m_valid[op] = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept(input logic [5:0] op);
    opcode = op; opcode_valid = 1'b1;
    tick();
    opcode_valid = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fetch_req && n < 50) begin tick(); n++; end
    if (!fetch_req) check("fetch_timeout", 0, 1);
  endtask

  // Expected issue sequence: walk RAM from the segment start until an EOS word,
  // or until the last address is issued without EOS.
  task automatic model_run(input logic [5:0] op);
    int a;
    exp_q.delete();
    if (op == 6'h3F) begin exp_end = 1; return; end
    if (!m_valid[op]) begin exp_end = 2; return; end
    a = int'(m_ptr[op]);
    forever begin
      exp_q.push_back(m_ram[a]);
      if (m_ram[a][0]) begin exp_end = 0; return; end
      if (a == 255) begin exp_end = 2; return; end
      a++;
    end
  endtask

  task automatic run_op(input logic [5:0] op, input int stall_pct);
    int n = 0;
    int lim;
    model_run(op);
    wait_fetch();
    obs_q.delete();
    accept(op);
    while (!(fetch_req || halted || fault) && n < 3000) begin
      stall = ($urandom_range(99) < stall_pct);
      tick();
      n++;
    end
    stall = 1'b0;
    if (n >= 3000) check("run_timeout", 0, 1);
    check("seg_len", obs_q.size(), exp_q.size());
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) check("seg_word", obs_q[i], exp_q[i]);
    check("end_fetch", fetch_req, exp_end == 0);
    check("end_halt",  halted,    exp_end == 1);
    check("end_fault", fault,     exp_end == 2);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    seg_we = 1'b0; seg_op = '0; seg_ptr = '0; start = 1'b0;
    opcode = '0; opcode_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 256; i++) m_ram[i] = '0;
    for (int i = 0; i < 64; i++) begin m_ptr[i] = '0; m_valid[i] = 1'b0; end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_ctrl", ctrl, 0);
    check("rst_cv", ctrl_valid, 0);
    check("rst_fetch", fetch_req, 0);
    check("rst_upc", upc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);

    // Basic two-word program with exact latency
    cfg_write(8'h00, 32'h318, 1);
    cfg_write(8'h01, 32'h181, 1);
    seg_write(6'd0, 8'h00, 1);
    do_start();
    check("start_fetch", fetch_req, 1);
    check("start_busy", busy, 1);
    accept(6'd0);
    check("disp_cv", ctrl_valid, 0);
    check("disp_fetch", fetch_req, 0);
    tick();
    check("exec0_cv", ctrl_valid, 0);
    tick();
    check("w0_cv", ctrl_valid, 1);
    check("w0_ctrl", ctrl, 32'h318);
    tick();
    check("w1_cv", ctrl_valid, 1);
    check("w1_ctrl", ctrl, 32'h181);
    tick();
    check("eos_fetch", fetch_req, 1);
    check("eos_cv", ctrl_valid, 0);

    // Stall after the first word
    accept(6'd0);
    tick();
    tick();
    check("st_w0", ctrl, 32'h318);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_cv", ctrl_valid, 0);
      check("st_ctrl", ctrl, 32'h318);
      check("st_upc", upc, 1);
    end
    stall = 1'b0;
    tick();
    check("st_w1_cv", ctrl_valid, 1);
    check("st_w1", ctrl, 32'h181);
    tick();
    check("st_fetch", fetch_req, 1);

    // Halt opcode and restart
    accept(6'h3F);
    check("halt_halted", halted, 1);
    check("halt_ctrl", ctrl, 0);
    check("halt_busy", busy, 0);
    check("halt_fetch", fetch_req, 0);
    do_start();
    check("rs_halted", halted, 0);
    check("rs_fetch", fetch_req, 1);

    // Writes while busy are ignored; undefined opcode faults
    cfg_write(8'h00, 32'h1, 0);
    seg_write(6'd5, 8'h00, 0);
    accept(6'd5);
    check("flt_fault", fault, 1);
    check("flt_cv", ctrl_valid, 0);
    check("flt_ctrl", ctrl, 0);
    tick();
    check("flt_cv2", ctrl_valid, 0);
    do_start();
    check("flt_clr", fault, 0);
    run_op(6'd0, 0);

    // Wrap-around at the top of RAM, programmed with simultaneous writes
    accept(6'h3F);
    both_write(8'hFE, 32'h2, 6'd1, 8'hFE);
    cfg_write(8'hFF, 32'h4, 1);
    do_start();
    run_op(6'd1, 0);

    // Asynchronous reset mid-EXEC clears dispatch valid bits
    seg_write(6'd7, 8'h10, 1);
    cfg_write(8'h10, 32'h1, 1);
    do_start();
    accept(6'd0);
    tick();
    tick();
    check("pre_rst_cv", ctrl_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", ctrl, 0);
    check("arst_cv", ctrl_valid, 0);
    check("arst_upc", upc, 0);
    check("arst_busy", busy, 0);
    check("arst_fetch", fetch_req, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_fetch", fetch_req, 0);
    do_start();
    accept(6'd7);
    check("post_rst_fault", fault, 1);

    // Randomized programs, opcodes and stalls
    for (int a = 0; a < 256; a++) begin
      logic [31:0] w;
      w = $urandom();
      w[0] = ($urandom_range(2) == 0);
      cfg_write(a[7:0], w, 1);
    end
    for (int i = 0; i < 63; i++)
      if ($urandom_range(3) != 0) seg_write(i[5:0], 8'($urandom()), 1);
    do_start();
    for (int r = 0; r < 40; r++) begin
      logic [5:0] op;
      op = ($urandom_range(7) == 0) ? 6'h3F : 6'($urandom());
      run_op(op, 30);
      if (exp_end != 0) do_start();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
